// File: rtl/gates7_accum.sv
// Packet-wide bitwise reducer: folds every beat of a packet with the op taken from its first beat.
// Latency: the result is valid one cycle after the last beat is accepted.
// Backpressure: in_ready is low while a result is pending; the result is held until out_ready.
// Optional beat counter is selected by GATES7_ACCUM_COUNT_EN.
module gates7_accum #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    input  logic [2:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_err,
    output logic [COUNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d, res;
    logic [2:0]         op_q, op_eff;
    logic               accept, finish, err_d;

    assign accept = in_valid && in_ready;
    assign finish = accept && in_last;
    // The first beat carries the op for the whole packet; later beats use the latched copy.
    assign op_eff = (state_q == IDLE) ? op : op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE, ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) state_d = in_last ? HOLD : ACCUM;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        if (accept) begin
            if (state_q == IDLE) begin
                acc_d = in_data;
            end else begin
                case (op_q)
                    3'd0, 3'd3: acc_d = acc_q & in_data;
                    3'd1, 3'd4: acc_d = acc_q | in_data;
                    3'd5, 3'd6: acc_d = acc_q ^ in_data;
                    default:    acc_d = in_data;
                endcase
            end
        end
    end

    always_comb begin
        res   = acc_d;
        err_d = 1'b0;
        case (op_eff)
            3'd0, 3'd1, 3'd5:       res = acc_d;
            3'd2, 3'd3, 3'd4, 3'd6: res = ~acc_d;
            default: begin
                res   = '0;
                err_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            op_q     <= 3'd0;
            out_data <= '0;
            out_err  <= 1'b0;
        end else begin
            if (accept) begin
                acc_q <= acc_d;
                if (state_q == IDLE) op_q <= op;
            end
            if (finish) begin
                out_data <= res;
                out_err  <= err_d;
            end
        end
    end

`ifdef GATES7_ACCUM_COUNT_EN
    logic [COUNT_W-1:0] count_q, count_d;

    // Saturates rather than wrapping so long packets report the maximum.
    always_comb begin
        count_d = count_q;
        if (accept) begin
            if (state_q == IDLE)     count_d = COUNT_W'(1);
            else if (count_q != '1)  count_d = count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            out_count <= '0;
        end else begin
            count_q <= count_d;
            if (finish) out_count <= count_d;
        end
    end
`else
    assign out_count = '0;
`endif

endmodule

// File: tb/tb_gates7_accum.sv
// Directed bench for gates7_accum at WIDTH=8, COUNT_W=2; count expectations follow GATES7_ACCUM_COUNT_EN.
module tb_gates7_accum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, in_last;
    logic [7:0] in_data;
    logic [2:0] op;
    logic       out_valid, out_ready, out_err;
    logic [7:0] out_data;
    logic [1:0] out_count;

    int errors = 0;
    int checks = 0;

`ifdef GATES7_ACCUM_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    gates7_accum #(.WIDTH(8), .COUNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .out_count(out_count)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] exp_cnt(input int n);
        return CNT_EN ? 2'(n) : 2'd0;
    endfunction

    // Offers one beat and returns #1 after the edge that takes it.
    task automatic beat(input logic [7:0] d, input logic l, input logic [2:0] o);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = l; op = o;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; op = 3'd0; out_ready = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_err !== 1'b0 || out_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h err=%b cnt=%0d, want 0 00 0 0",
                     out_valid, out_data, out_err, out_count);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_and();
        beat(8'hF0, 1'b0, 3'd0);
        beat(8'h3C, 1'b0, 3'd1);   // op change mid-packet must be ignored
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL and_early_valid: got %b want 0", out_valid);
        end
        in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1; op = 3'd4;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h30 || out_err !== 1'b0 || out_count !== exp_cnt(3)) begin
            errors++;
            $display("FAIL and_result: got valid=%b data=%h err=%b cnt=%0d, want 1 30 0 %0d",
                     out_valid, out_data, out_err, out_count, exp_cnt(3));
        end
        drain();
    endtask

    task automatic test_xnor_not();
        beat(8'hAA, 1'b0, 3'd6);
        beat(8'h0F, 1'b1, 3'd0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A || out_count !== exp_cnt(2)) begin
            errors++;
            $display("FAIL xnor_result: got valid=%b data=%h cnt=%0d, want 1 5a %0d",
                     out_valid, out_data, out_count, exp_cnt(2));
        end
        drain();
        beat(8'h0F, 1'b1, 3'd2);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hF0 || out_count !== exp_cnt(1) || out_err !== 1'b0) begin
            errors++;
            $display("FAIL not_single: got valid=%b data=%h cnt=%0d err=%b, want 1 f0 %0d 0",
                     out_valid, out_data, out_count, out_err, exp_cnt(1));
        end
        drain();
    endtask

    task automatic test_hold();
        int bad = 0;
        beat(8'h01, 1'b0, 3'd1);
        beat(8'h02, 1'b0, 3'd1);
        beat(8'h04, 1'b1, 3'd1);
        // A competing beat stays offered through the hold and the handshake cycle.
        in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b1; op = 3'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== 8'h07 || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: %0d bad cycles (last valid=%b data=%h in_ready=%b), want 0",
                     bad, out_valid, out_data, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_data !== 8'h07 || out_count !== exp_cnt(3) || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_keeps_outputs: got data=%h cnt=%0d valid=%b, want 07 %0d 0",
                     out_data, out_count, out_valid, exp_cnt(3));
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 4; i++) beat(8'h01, 1'b0, 3'd5);
        beat(8'h01, 1'b1, 3'd5);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h01 || out_count !== exp_cnt(3)) begin
            errors++;
            $display("FAIL xor_saturate: got valid=%b data=%h cnt=%0d, want 1 01 %0d",
                     out_valid, out_data, out_count, exp_cnt(3));
        end
        drain();
    endtask

    task automatic test_reserved();
        beat(8'h55, 1'b1, 3'd7);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h00 || out_err !== 1'b1) begin
            errors++;
            $display("FAIL reserved_op: got valid=%b data=%h err=%b, want 1 00 1",
                     out_valid, out_data, out_err);
        end
        drain();
        beat(8'hC3, 1'b1, 3'd0);
        checks++;
        if (out_err !== 1'b0 || out_data !== 8'hC3) begin
            errors++;
            $display("FAIL err_clears: got err=%b data=%h, want 0 c3", out_err, out_data);
        end
        drain();
    endtask

    task automatic test_mid_reset();
        int bad = 0;
        beat(8'hF0, 1'b0, 3'd0);
        beat(8'h3C, 1'b0, 3'd0);
        @(negedge clk); rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_count !== 2'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got valid=%b data=%h cnt=%0d, want 0 00 0",
                     out_valid, out_data, out_count);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midreset_idle: %0d bad cycles (valid=%b in_ready=%b), want 0", bad, out_valid, in_ready);
        end
        beat(8'h0F, 1'b0, 3'd0);
        beat(8'h3C, 1'b1, 3'd0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h0C || out_count !== exp_cnt(2)) begin
            errors++;
            $display("FAIL midreset_next: got valid=%b data=%h cnt=%0d, want 1 0c %0d",
                     out_valid, out_data, out_count, exp_cnt(2));
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_and();
        test_xnor_not();
        test_hold();
        test_saturate();
        test_reserved();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gates7_accum.md
GATES7_ACCUM -- requirements
Module: gates7_accum

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: data word width in bits, minimum 1.
REQ-002 SHALL provide parameter COUNT_W, default 8: beat-counter width in bits, minimum 2.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1: input beat offered.
REQ-006 SHALL have port in_ready  output  1: block accepts a beat this cycle.
REQ-007 SHALL have port in_data  input  WIDTH: operand word.
REQ-008 SHALL have port in_last  input  1: final beat of the packet.
REQ-009 SHALL have port op  input  3: function code: 0 AND, 1 OR, 2 NOT, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 reserved.
REQ-010 SHALL have port out_valid  output  1: result available.
REQ-011 SHALL have port out_ready  input  1: consumer accepts the result.
REQ-012 SHALL have port out_data  output  WIDTH: packet result.
REQ-013 SHALL have port out_err  output  1: the packet used reserved op 7.
REQ-014 SHALL have port out_count  output  COUNT_W: number of beats in the packet.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM and HOLD.
REQ-016 A beat SHALL be accepted exactly when in_valid and in_ready are both 1.
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD.
REQ-018 In IDLE, an accepted beat SHALL latch op, load acc with in_data and set count to 1.
- It SHALL move to HOLD if in_last=1, otherwise to ACCUM.
REQ-019 In ACCUM, each accepted beat SHALL update acc and increment count, moving to HOLD on in_last=1.
- Update: AND/NAND acc&in_data; OR/NOR acc|in_data; XOR/XNOR acc^in_data; NOT acc=in_data.
REQ-020 op SHALL be sampled only on the first beat; op changes mid-packet SHALL be ignored.
REQ-021 On entering HOLD, out_valid SHALL assert with a latency of one cycle after the last beat is accepted.
- out_data SHALL equal acc for AND/OR/XOR, and ~acc for NOT/NAND/NOR/XNOR.
REQ-022 For reserved op 7: out_data SHALL be all zeros and out_err SHALL be 1; otherwise out_err SHALL be 0.
REQ-023 out_valid, out_data, out_err and out_count SHALL stay stable in HOLD until out_ready=1.
- On that handshake the FSM SHALL return to IDLE.
- No new beat SHALL be accepted in the handshake cycle.
REQ-024 A single-beat packet (first beat with in_last=1) SHALL be legal and produce count 1.
REQ-025 In IDLE and ACCUM, out_valid SHALL be 0.
- out_data, out_err and out_count SHALL hold their last values.

Reset
REQ-026 When rst_n=0, the following SHALL be forced asynchronously:
- FSM to IDLE
- acc, count, out_data and out_count to 0
- out_valid and out_err to 0
- latched op to 0
REQ-027 Reset mid-packet or in HOLD SHALL discard the partial or pending result with no output handshake.
REQ-028 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-029 Macro GATES7_ACCUM_COUNT_EN SHALL select beat counting.
REQ-030 With GATES7_ACCUM_COUNT_EN defined, the count SHALL saturate at 2^COUNT_W-1, and out_count SHALL present the final count in HOLD.
REQ-031 Without GATES7_ACCUM_COUNT_EN, no counter SHALL be built and out_count SHALL be driven constant 0.
- All other behaviour SHALL be identical.

Verification (WIDTH=8, COUNT_W=2, GATES7_ACCUM_COUNT_EN defined unless noted)
REQ-032 op=0, beats 0xF0,0x3C,0xFF(last) -> out_data=0x30, out_count=3, out_err=0, out_valid one cycle after last beat.
REQ-033 op=6, beats 0xAA,0x0F(last) -> out_data=0x5A.
- Additionally, op=2 single beat 0x0F(last) -> out_data=0xF0, out_count=1.
REQ-034 op=1, beats 0x01,0x02,0x04(last), out_ready=0 for 5 cycles -> out_valid and out_data=0x07 held, in_ready=0 throughout.
- After out_ready=1: IDLE next cycle.
REQ-035 op=5, 5 beats each 0x01 -> out_data=0x01, out_count=3 (saturated).
- Without macro -> out_count=0.
REQ-036 op=7, beat 0x55(last) -> out_data=0x00, out_err=1.
- Additionally: rst_n pulsed low after 2 beats of an op=0 packet -> out_valid stays 0, in_ready=1 after release, next packet correct.
